instr_fetch_unit: RTL and testbench

- Upstream neighbour of the multicycle control FSM.
- Owns the PC and the instruction register (IR), and runs the instruction-memory read handshake.
- Decodes fixed IR fields (op, func, register indices, immediate) that feed the controller and datapath.
- Consumes the controller's IntMemRead, IRWrite, PCWrite, PCWriteCond, FlagSel and PCSrc strobes.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/ifu_pc_reg.sv | 36 +++
 rtl/instr_fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: IR field positions, fetch FSM states, reset constants.
package cpu_pkg;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 28;
  localparam int RD_MSB   = 27;
  localparam int RD_LSB   = 24;
  localparam int RS_MSB   = 23;
  localparam int RS_LSB   = 20;
  localparam int RT_MSB   = 19;
  localparam int RT_LSB   = 16;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int FUNC_MSB = 3;
  localparam int FUNC_LSB = 0;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter with next-PC select: unconditional write has priority over a taken branch.
module ifu_pc_reg #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pc_write,
  input  logic              i_pc_write_cond,
  input  logic              i_flag_sel,
  input  logic              i_pc_src,
  input  logic              i_zero_flag,
  input  logic [ADDR_W-1:0] i_alu_result,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;
  logic              w_branch_taken;

  // flag_sel=1 turns the branch into "branch if not zero"
  assign w_branch_taken = i_pc_write_cond & (i_flag_sel ? ~i_zero_flag : i_zero_flag);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (i_pc_write) begin
      r_pc <= i_pc_src ? i_branch_target : i_alu_result;
    end else if (w_branch_taken) begin
      r_pc <= i_branch_target;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, IR, instruction-memory read handshake and fixed IR field decode.
// Optional REQ watchdog enabled by defining IFU_TIMEOUT_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                INSTR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               int_mem_read,
  input  logic               ir_write,
  input  logic               pc_write,
  input  logic               pc_write_cond,
  input  logic               flag_sel,
  input  logic               pc_src,
  input  logic               zero_flag,
  input  logic [ADDR_W-1:0]  alu_result,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               fetch_busy,
  output logic               fetch_valid,
  output logic               fetch_err,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         op,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic [15:0]        imm,
  output logic [3:0]         func
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  fetch_state_e       r_state, w_state_nxt;
  logic               r_imem_req, w_imem_req_nxt;
  logic [ADDR_W-1:0]  r_imem_addr, w_imem_addr_nxt;
  logic [INSTR_W-1:0] r_buf, w_buf_nxt;
  logic [INSTR_W-1:0] r_ir, w_ir_nxt;
  logic [ADDR_W-1:0]  w_pc;

  ifu_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .i_pc_write      (pc_write),
    .i_pc_write_cond (pc_write_cond),
    .i_flag_sel      (flag_sel),
    .i_pc_src        (pc_src),
    .i_zero_flag     (zero_flag),
    .i_alu_result    (alu_result),
    .i_branch_target (branch_target),
    .o_pc            (w_pc)
  );

`ifdef IFU_TIMEOUT_EN
  // Down-counter loaded on REQ entry; terminal count 0 means TIMEOUT_CYC REQ cycles have elapsed
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wdog, w_wdog_nxt;
  logic            r_err, w_err_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH_IDLE;
      r_imem_req  <= 1'b0;
      r_imem_addr <= '0;
      r_buf       <= '0;
      r_ir        <= '0;
`ifdef IFU_TIMEOUT_EN
      r_wdog      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_imem_req  <= w_imem_req_nxt;
      r_imem_addr <= w_imem_addr_nxt;
      r_buf       <= w_buf_nxt;
      r_ir        <= w_ir_nxt;
`ifdef IFU_TIMEOUT_EN
      r_wdog      <= w_wdog_nxt;
      r_err       <= w_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_imem_req_nxt  = r_imem_req;
    w_imem_addr_nxt = r_imem_addr;
    w_buf_nxt       = r_buf;
    w_ir_nxt        = r_ir;
`ifdef IFU_TIMEOUT_EN
    w_wdog_nxt      = r_wdog;
    w_err_nxt       = r_err;
`endif
    case (r_state)
      FETCH_IDLE: begin
        if (int_mem_read) begin
          w_state_nxt     = FETCH_REQ;
          w_imem_req_nxt  = 1'b1;
          w_imem_addr_nxt = w_pc;
`ifdef IFU_TIMEOUT_EN
          w_wdog_nxt      = WD_W'(TIMEOUT_CYC - 1);
`endif
        end
      end
      FETCH_REQ: begin
        if (imem_ack) begin
          w_imem_req_nxt = 1'b0;
`ifdef IFU_TIMEOUT_EN
          w_wdog_nxt     = '0;
`endif
          // Same-cycle ir_write skips the buffer and DONE entirely
          if (ir_write) begin
            w_ir_nxt    = imem_rdata;
            w_state_nxt = FETCH_IDLE;
          end else begin
            w_buf_nxt   = imem_rdata;
            w_state_nxt = FETCH_DONE;
          end
        end
`ifdef IFU_TIMEOUT_EN
        else if (r_wdog == '0) begin
          w_imem_req_nxt = 1'b0;
          w_buf_nxt      = INSTR_W'(NOP_INSTR);
          w_err_nxt      = 1'b1;
          w_state_nxt    = FETCH_DONE;
        end else begin
          w_wdog_nxt = r_wdog - 1'b1;
        end
`endif
      end
      FETCH_DONE: begin
        if (ir_write) begin
          w_ir_nxt    = r_buf;
          w_state_nxt = FETCH_IDLE;
        end
      end
      default: begin
        w_state_nxt    = FETCH_IDLE;
        w_imem_req_nxt = 1'b0;
      end
    endcase
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign fetch_busy  = (r_state == FETCH_REQ);
  assign fetch_valid = (r_state == FETCH_DONE);
  assign pc          = w_pc;
  assign ir          = r_ir;
`ifdef IFU_TIMEOUT_EN
  assign fetch_err   = r_err;
`else
  assign fetch_err   = 1'b0;
`endif

  assign op   = r_ir[OP_MSB:OP_LSB];
  assign rd   = r_ir[RD_MSB:RD_LSB];
  assign rs   = r_ir[RS_MSB:RS_LSB];
  assign rt   = r_ir[RT_MSB:RT_LSB];
  assign imm  = r_ir[IMM_MSB:IMM_LSB];
  assign func = r_ir[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, randomized run against a
// transaction-level model, and a long no-ack wait (watchdog behaviour when IFU_TIMEOUT_EN is set).
module tb_instr_fetch_unit;

  localparam int TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        rst, int_mem_read, ir_write, pc_write, pc_write_cond, flag_sel, pc_src, zero_flag;
  logic [31:0] alu_result, branch_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        fetch_busy, fetch_valid, fetch_err;
  logic [31:0] pc, ir;
  logic [3:0]  op, rd, rs, rt, func;
  logic [15:0] imm;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W      (32),
    .INSTR_W     (32),
    .RESET_PC    (32'h0),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .int_mem_read  (int_mem_read),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .flag_sel      (flag_sel),
    .pc_src        (pc_src),
    .zero_flag     (zero_flag),
    .alu_result    (alu_result),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .fetch_busy    (fetch_busy),
    .fetch_valid   (fetch_valid),
    .fetch_err     (fetch_err),
    .pc            (pc),
    .ir            (ir),
    .op            (op),
    .rd            (rd),
    .rs            (rs),
    .rt            (rt),
    .imm           (imm),
    .func          (func)
  );

  typedef struct {
    logic        rst, imr, irw, pcw, pcwc, fsel, psrc, zero, ack;
    logic [31:0] alu, bt, rdata;
    logic [31:0] e_pc, e_ir, e_addr;
    logic        e_req, e_valid;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic imr, input logic irw, input logic pcw,
                     input logic pcwc, input logic fsel, input logic psrc, input logic zero,
                     input logic [31:0] alu, input logic [31:0] bt, input logic ack,
                     input logic [31:0] rdata, input logic [31:0] e_pc, input logic [31:0] e_ir,
                     input logic e_req, input logic [31:0] e_addr, input logic e_valid);
    vec_t v;
    v.rst = r; v.imr = imr; v.irw = irw; v.pcw = pcw; v.pcwc = pcwc; v.fsel = fsel;
    v.psrc = psrc; v.zero = zero; v.alu = alu; v.bt = bt; v.ack = ack; v.rdata = rdata;
    v.e_pc = e_pc; v.e_ir = e_ir; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    rst = 0; int_mem_read = 0; ir_write = 0; pc_write = 0; pc_write_cond = 0;
    flag_sel = 0; pc_src = 0; zero_flag = 0; alu_result = 0; branch_target = 0;
    imem_ack = 0; imem_rdata = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference: one outstanding read, one buffered word, sticky error
  logic [31:0] m_pc, m_ir, m_buf, m_addr;
  logic        m_out, m_have, m_err;
  int          m_wait;

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_buf = 0; m_addr = 0; m_out = 0; m_have = 0; m_err = 0; m_wait = 0;
  endtask

  task automatic model_tick();
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (rst) begin
      model_reset();
    end else begin
      if (pc_write) m_pc = pc_src ? branch_target : alu_result;
      else if (pc_write_cond && (flag_sel ? !zero_flag : zero_flag)) m_pc = branch_target;
      if (m_out) begin
        if (imem_ack) begin
          m_out = 0;
          if (ir_write) m_ir = imem_rdata;
          else begin m_buf = imem_rdata; m_have = 1; end
        end else begin
          m_wait++;
`ifdef IFU_TIMEOUT_EN
          if (m_wait == TIMEOUT_CYC) begin
            m_out = 0; m_have = 1; m_buf = 0; m_err = 1;
          end
`endif
        end
      end else if (m_have) begin
        if (ir_write) begin m_ir = m_buf; m_have = 0; end
      end else if (int_mem_read) begin
        m_out = 1; m_addr = old_pc; m_wait = 0;
      end
    end
  endtask

  task automatic check_model(input int cyc);
    string s;
    s = $sformatf("rnd%0d", cyc);
    chk({s, "_pc"},    pc, m_pc);
    chk({s, "_ir"},    ir, m_ir);
    chk({s, "_req"},   imem_req, m_out);
    chk({s, "_busy"},  fetch_busy, m_out);
    chk({s, "_valid"}, fetch_valid, m_have);
    chk({s, "_err"},   fetch_err, m_err);
    if (m_out) chk({s, "_addr"}, imem_addr, m_addr);
    chk({s, "_op"},    op, m_ir[31:28]);
    chk({s, "_imm"},   imm, m_ir[15:0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    drive_idle();

    //   rst imr irw pcw pcwc fs ps z  alu     bt        ack rdata          e_pc     e_ir          req addr     valid
    add(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h0,   32'h0,        0, 32'h0,   0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h0,   32'h0,        0, 32'h0,   0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h0,   32'h0,        1, 32'h0,   0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h0,   32'h0,        1, 32'h0,   0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h0,   32'h0,        1, 32'h0,   0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   1, 32'h81234005, 32'h0,   32'h0,        0, 32'h0,   1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h0,   32'h81234005, 0, 32'h0,   0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h0,   32'h81234005, 1, 32'h0,   0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 32'h0,  32'h0,   1, 32'h30000010, 32'h0,   32'h30000010, 0, 32'h0,   0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 32'h0,  32'h40,  0, 32'h0,        32'h40,  32'h30000010, 0, 32'h0,   0);
    add(0, 0, 0, 0, 1, 1, 0, 1, 32'h0,  32'h80,  0, 32'h0,        32'h40,  32'h30000010, 0, 32'h0,   0);
    add(0, 0, 0, 1, 1, 0, 0, 1, 32'h44, 32'h40,  0, 32'h0,        32'h44,  32'h30000010, 0, 32'h0,   0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 32'h4,  32'h100, 0, 32'h0,        32'h100, 32'h30000010, 0, 32'h0,   0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 32'h0,  32'h200, 0, 32'h0,        32'h200, 32'h30000010, 0, 32'h0,   0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h200, 32'h30000010, 1, 32'h200, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h0,   32'h0,        0, 32'h0,   0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   1, 32'hdeadbeef, 32'h0,   32'h0,        0, 32'h0,   0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h0,   32'h0,        0, 32'h0,   0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h0,   32'h0,        1, 32'h0,   0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 32'h0,  32'h300, 0, 32'h0,        32'h300, 32'h0,        1, 32'h0,   0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h300, 32'h0,        1, 32'h0,   0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   1, 32'h12345678, 32'h300, 32'h0,        0, 32'h0,   1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h300, 32'h0,        0, 32'h0,   1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 32'h0,  32'h0,   0, 32'h0,        32'h300, 32'h12345678, 0, 32'h0,   0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 32'h0,  32'h0,   1, 32'h55555555, 32'h300, 32'h12345678, 0, 32'h0,   0);

    for (int i = 0; i < vq.size(); i++) begin
      logic [31:0] eir;
      string s;
      rst = vq[i].rst; int_mem_read = vq[i].imr; ir_write = vq[i].irw; pc_write = vq[i].pcw;
      pc_write_cond = vq[i].pcwc; flag_sel = vq[i].fsel; pc_src = vq[i].psrc;
      zero_flag = vq[i].zero; alu_result = vq[i].alu; branch_target = vq[i].bt;
      imem_ack = vq[i].ack; imem_rdata = vq[i].rdata;
      step();
      eir = vq[i].e_ir;
      s = $sformatf("vec%0d", i);
      chk({s, "_pc"},    pc, vq[i].e_pc);
      chk({s, "_ir"},    ir, eir);
      chk({s, "_req"},   imem_req, vq[i].e_req);
      chk({s, "_busy"},  fetch_busy, vq[i].e_req);
      chk({s, "_valid"}, fetch_valid, vq[i].e_valid);
      chk({s, "_err"},   fetch_err, 1'b0);
      if (vq[i].e_req) chk({s, "_addr"}, imem_addr, vq[i].e_addr);
      chk({s, "_op"},    op, eir[31:28]);
      chk({s, "_rd"},    rd, eir[27:24]);
      chk({s, "_rs"},    rs, eir[23:20]);
      chk({s, "_rt"},    rt, eir[19:16]);
      chk({s, "_imm"},   imm, eir[15:0]);
      chk({s, "_func"},  func, eir[3:0]);
    end

    // Randomized run against the reference model
    drive_idle();
    rst = 1;
    model_tick();
    step();
    check_model(-1);
    for (int c = 0; c < 500; c++) begin
      rst           = ($urandom_range(0, 59) == 0);
      int_mem_read  = ($urandom_range(0, 1) == 1);
      ir_write      = ($urandom_range(0, 2) == 0);
      pc_write      = ($urandom_range(0, 4) == 0);
      pc_write_cond = ($urandom_range(0, 3) == 0);
      flag_sel      = $urandom_range(0, 1) == 1;
      pc_src        = $urandom_range(0, 1) == 1;
      zero_flag     = $urandom_range(0, 1) == 1;
      alu_result    = $urandom;
      branch_target = $urandom;
      imem_ack      = ($urandom_range(0, 2) == 0);
      imem_rdata    = $urandom;
      model_tick();
      step();
      check_model(c);
    end

    // Long wait with no ack: watchdog fires only when the feature is built in
    drive_idle();
    rst = 1;
    step();
    rst = 0;
    int_mem_read = 1;
    step();
    int_mem_read = 0;
    for (int k = 0; k < TIMEOUT_CYC - 1; k++) step();
    chk("wd_busy_before", fetch_busy, 1'b1);
    chk("wd_err_before", fetch_err, 1'b0);
    step();
`ifdef IFU_TIMEOUT_EN
    chk("wd_err_at_limit", fetch_err, 1'b1);
    chk("wd_valid_at_limit", fetch_valid, 1'b1);
    chk("wd_req_at_limit", imem_req, 1'b0);
    ir_write = 1;
    step();
    ir_write = 0;
    chk("wd_ir_nop", ir, 32'h0);
    chk("wd_err_sticky", fetch_err, 1'b1);
    rst = 1;
    step();
    rst = 0;
    chk("wd_err_cleared", fetch_err, 1'b0);
`else
    for (int k = 0; k < 20; k++) step();
    chk("nowd_still_busy", fetch_busy, 1'b1);
    chk("nowd_still_req", imem_req, 1'b1);
    chk("nowd_err_zero", fetch_err, 1'b0);
    chk("nowd_valid_zero", fetch_valid, 1'b0);
    imem_ack = 1;
    imem_rdata = 32'ha5a5_0001;
    step();
    imem_ack = 0;
    chk("nowd_late_ack_valid", fetch_valid, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
